// File: rtl/dcache_axi_refill.sv
// ---------------------------------------------------------------------------
// dcache_axi_refill
//   Line-refill / write-back engine between the data cache miss logic and an
//   AXI4 master port. On a miss it optionally writes the dirty victim line
//   out (AW, 8 W beats, B), then reads the missing line in (AR, 8 R beats),
//   streams each beat into the cache data RAM, and pulses o_reload once so
//   the cache installs the tag and releases its stall.
//
// Ports
//   i_clk, i_rst             : clock, synchronous active-high reset
//   i_rd_req / i_rd_addr     : miss pending, line-aligned refill address
//   i_wr_req / i_wr_addr     : victim needs write-back, victim line address
//   o_reload                 : one-cycle tag-commit pulse
//   o_vic_idx / i_vic_rdata  : victim data RAM read (combinational RAM)
//   o_ref_we/_idx/_wdata     : refill write port to the cache data RAM
//   AR/R, AW/W/B             : AXI4 master channels (fixed 8x32-bit INCR)
//   o_bus_err                : sticky, set by any non-OKAY RRESP/BRESP
//
// Configuration
//   DCACHE_WB_OVERLAP_EN : when defined, the refill AR is issued right after
//   the last write-back W beat and the B response is collected in the
//   background (b_pending); DONE waits until that response has arrived.
// ---------------------------------------------------------------------------
module dcache_axi_refill #(
  parameter logic [3:0] AXI_ID     = 4'd1,
  parameter int         LINE_BEATS = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rd_req,
  input  logic [31:0] i_rd_addr,
  input  logic        i_wr_req,
  input  logic [31:0] i_wr_addr,
  output logic        o_reload,
  output logic [2:0]  o_vic_idx,
  input  logic [31:0] i_vic_rdata,
  output logic        o_ref_we,
  output logic [2:0]  o_ref_idx,
  output logic [31:0] o_ref_wdata,
  output logic [3:0]  o_arid,
  output logic [31:0] o_araddr,
  output logic [7:0]  o_arlen,
  output logic [2:0]  o_arsize,
  output logic [1:0]  o_arburst,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rlast,
  input  logic        i_rvalid,
  output logic        o_rready,
  output logic [3:0]  o_awid,
  output logic [31:0] o_awaddr,
  output logic [7:0]  o_awlen,
  output logic [2:0]  o_awsize,
  output logic [1:0]  o_awburst,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_wlast,
  output logic        o_wvalid,
  input  logic        i_wready,
  input  logic [1:0]  i_bresp,
  input  logic        i_bvalid,
  output logic        o_bready,
  output logic        o_bus_err
);

  localparam logic [2:0] LAST_BEAT = 3'(LINE_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WB_AW, S_WB_W, S_WB_B, S_RD_AR, S_RD_R, S_DONE
  } state_t;

  state_t      r_state;
  logic [2:0]  r_beat;
  logic [31:0] r_araddr, r_awaddr;
  logic        r_arvalid, r_awvalid, r_wvalid, r_bready, r_rready;
  logic        r_reload, r_bus_err;
`ifdef DCACHE_WB_OVERLAP_EN
  logic        r_b_pending;
`endif

  logic w_w_hs, w_r_hs, w_b_hs, w_last_beat;
  assign w_w_hs      = r_wvalid & i_wready;
  assign w_r_hs      = r_rready & i_rvalid;
  assign w_b_hs      = r_bready & i_bvalid;
  assign w_last_beat = (r_beat == LAST_BEAT);

  // Sequencing counts refill beats, not RLAST; keep the input visibly sunk.
  logic w_unused_rlast;
  assign w_unused_rlast = i_rlast;

  // NOTE: all state below uses non-blocking (<=) assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_beat    <= 3'd0;
      r_araddr  <= 32'd0;
      r_awaddr  <= 32'd0;
      r_arvalid <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_rready  <= 1'b0;
      r_reload  <= 1'b0;
      r_bus_err <= 1'b0;
`ifdef DCACHE_WB_OVERLAP_EN
      r_b_pending <= 1'b0;
`endif
    end else begin
      if ((w_r_hs && i_rresp != 2'b00) || (w_b_hs && i_bresp != 2'b00))
        r_bus_err <= 1'b1;

`ifdef DCACHE_WB_OVERLAP_EN
      // Background B collection while the refill is already running.
      if (r_b_pending && i_bvalid) begin
        r_b_pending <= 1'b0;
        r_bready    <= 1'b0;
      end
`endif

      case (r_state)
        S_IDLE: begin
          if (i_rd_req) begin
            r_araddr <= i_rd_addr;
            r_awaddr <= i_wr_addr;
            r_beat   <= 3'd0;
            if (i_wr_req) begin
              r_state   <= S_WB_AW;
              r_awvalid <= 1'b1;
            end else begin
              r_state   <= S_RD_AR;
              r_arvalid <= 1'b1;
            end
          end
        end
        S_WB_AW: begin
          if (i_awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_state   <= S_WB_W;
          end
        end
        S_WB_W: begin
          if (w_w_hs) begin
            r_beat <= r_beat + 3'd1;  // wraps to 0 after the last beat
            if (w_last_beat) begin
              r_wvalid <= 1'b0;
              r_bready <= 1'b1;
`ifdef DCACHE_WB_OVERLAP_EN
              r_b_pending <= 1'b1;
              r_arvalid   <= 1'b1;
              r_state     <= S_RD_AR;
`else
              r_state     <= S_WB_B;
`endif
            end
          end
        end
        S_WB_B: begin
          if (i_bvalid) begin
            r_bready <= 1'b0;
`ifdef DCACHE_WB_OVERLAP_EN
            // Only reached after the refill finished with B still owed.
            r_reload <= 1'b1;
            r_state  <= S_DONE;
`else
            r_arvalid <= 1'b1;
            r_state   <= S_RD_AR;
`endif
          end
        end
        S_RD_AR: begin
          if (i_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_R;
          end
        end
        S_RD_R: begin
          if (w_r_hs) begin
            r_beat <= r_beat + 3'd1;
            if (w_last_beat) begin
              r_rready <= 1'b0;
`ifdef DCACHE_WB_OVERLAP_EN
              if (r_b_pending && !i_bvalid) begin
                r_state <= S_WB_B;
              end else begin
                r_reload <= 1'b1;
                r_state  <= S_DONE;
              end
`else
              r_reload <= 1'b1;
              r_state  <= S_DONE;
`endif
            end
          end
        end
        S_DONE: begin
          r_reload <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_reload    = r_reload;
  assign o_vic_idx   = r_beat;
  assign o_ref_we    = r_rready & i_rvalid;
  assign o_ref_idx   = r_beat;
  assign o_ref_wdata = i_rdata;

  assign o_arid    = AXI_ID;
  assign o_araddr  = r_araddr;
  assign o_arlen   = 8'(LINE_BEATS - 1);
  assign o_arsize  = 3'b010;
  assign o_arburst = 2'b01;
  assign o_arvalid = r_arvalid;
  assign o_rready  = r_rready;

  assign o_awid    = AXI_ID;
  assign o_awaddr  = r_awaddr;
  assign o_awlen   = 8'(LINE_BEATS - 1);
  assign o_awsize  = 3'b010;
  assign o_awburst = 2'b01;
  assign o_awvalid = r_awvalid;

  assign o_wdata   = i_vic_rdata;
  assign o_wstrb   = 4'hF;
  assign o_wlast   = r_wvalid & w_last_beat;
  assign o_wvalid  = r_wvalid;
  assign o_bready  = r_bready;
  assign o_bus_err = r_bus_err;

endmodule

// File: tb/tb_dcache_axi_refill.sv
// ---------------------------------------------------------------------------
// tb_dcache_axi_refill
//   Directed bench for dcache_axi_refill: clean miss with exact reload
//   timing, dirty miss with write-back ordering, back-pressure on W and R,
//   sticky error response, and reset in the middle of a refill.
// ---------------------------------------------------------------------------
module tb_dcache_axi_refill;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, wr_req;
  logic [31:0] rd_addr, wr_addr;
  logic        reload;
  logic [2:0]  vic_idx;
  logic [31:0] vic_rdata;
  logic        ref_we;
  logic [2:0]  ref_idx;
  logic [31:0] ref_wdata;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, arready, awvalid, awready;
  logic [31:0] rdata, wdata;
  logic [1:0]  rresp, bresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bvalid, bready, bus_err;

  int n_checks = 0;
  int n_fail   = 0;
  int reload_cnt = 0;
  int aw_cnt     = 0;

  always #5 clk = ~clk;

  // Victim data RAM model: word i of the victim line holds 0x5500 + i.
  assign vic_rdata = 32'h0000_5500 + {29'd0, vic_idx};

  always @(posedge clk) begin
    if (reload)  reload_cnt <= reload_cnt + 1;
    if (awvalid) aw_cnt     <= aw_cnt + 1;
  end

  dcache_axi_refill dut (
    .i_clk(clk), .i_rst(rst),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr),
    .o_reload(reload),
    .o_vic_idx(vic_idx), .i_vic_rdata(vic_rdata),
    .o_ref_we(ref_we), .o_ref_idx(ref_idx), .o_ref_wdata(ref_wdata),
    .o_arid(arid), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize),
    .o_arburst(arburst), .o_arvalid(arvalid), .i_arready(arready),
    .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast), .i_rvalid(rvalid),
    .o_rready(rready),
    .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize),
    .o_awburst(awburst), .o_awvalid(awvalid), .i_awready(awready),
    .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast), .o_wvalid(wvalid),
    .i_wready(wready),
    .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
    .o_bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge; inputs are driven
  // there and outputs checked 1 unit later, well clear of the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in RD_R; delivers 8 beats base+k with 'gap' idle cycles before
  // each, error response on beat err_beat. Returns in the cycle after the
  // 8th handshake.
  task automatic r_phase(input logic [31:0] base, input int err_beat, input int gap);
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < gap; g++) begin
        rvalid = 1'b0;
        #1 check("r_gap_ref_we", ref_we, 0);
        check("r_gap_rready", rready, 1);
        step();
      end
      rvalid = 1'b1;
      rdata  = base + k;
      rresp  = (k == err_beat) ? 2'b10 : 2'b00;
      rlast  = (k == 7);
      #1 check("ref_we", ref_we, 1);
      check("ref_idx", ref_idx, k);
      check("ref_wdata", ref_wdata, base + k);
      step();
    end
    rvalid = 1'b0;
    rresp  = 2'b00;
    rlast  = 1'b0;
  endtask

  task automatic clean_miss(input logic [31:0] raddr, input logic [31:0] base,
                            input int err_beat, input int gap);
    int rl0 = reload_cnt;
    int aw0 = aw_cnt;
    rd_req  = 1'b1;
    wr_req  = 1'b0;
    rd_addr = raddr;
    wr_addr = 32'hDEAD_0000;
    #1 check("idle_arvalid", arvalid, 0);
    step();
    // Address must stay latched even though rd_addr now changes.
    rd_req  = 1'b0;
    rd_addr = 32'hFFFF_FFC0;
    #1 check("arvalid", arvalid, 1);
    check("araddr", araddr, raddr);
    check("arlen", arlen, 7);
    check("arsize", arsize, 3'b010);
    check("arburst", arburst, 2'b01);
    check("arid", arid, 4'd1);
    step();
    r_phase(base, err_beat, gap);
    // With no gaps this is the 11th cycle counting the rd_req cycle as 1.
    #1 check("reload_pulse", reload, 1);
    step();
    #1 check("reload_low", reload, 0);
    check("reload_once", reload_cnt - rl0, 1);
    check("no_aw", aw_cnt - aw0, 0);
  endtask

  task automatic dirty_miss(input logic [31:0] waddr, input logic [31:0] raddr,
                            input logic [31:0] base, input bit toggle, input int gap);
    int exp_beat = 0;
    int rl0 = reload_cnt;
    rd_req  = 1'b1;
    wr_req  = 1'b1;
    rd_addr = raddr;
    wr_addr = waddr;
    step();
    rd_req = 1'b0;
    wr_req = 1'b0;
    #1 check("awvalid", awvalid, 1);
    check("awaddr", awaddr, waddr);
    check("awlen", awlen, 7);
    check("awburst_size", {awburst, awsize}, {2'b01, 3'b010});
    check("awid", awid, 4'd1);
    check("ar_before_wb", arvalid, 0);
    step();
    for (int c = 0; c < 40 && exp_beat < 8; c++) begin
      wready = toggle ? (c % 2 == 0) : 1'b1;
      #1 check("wvalid", wvalid, 1);
      check("vic_idx", vic_idx, exp_beat);
      check("wdata", wdata, 32'h5500 + exp_beat);
      check("wlast", wlast, exp_beat == 7);
      check("wstrb", wstrb, 4'hF);
      if (wready) exp_beat++;
      step();
    end
    check("w_beats_done", exp_beat, 8);
    wready = 1'b0;
`ifdef DCACHE_WB_OVERLAP_EN
    #1 check("ar_after_wlast", arvalid, 1);
    check("bready_pending", bready, 1);
    check("wvalid_off", wvalid, 0);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    #1 check("bready_cleared", bready, 0);
    check("ar_done", arvalid, 0);
`else
    #1 check("bready", bready, 1);
    check("ar_waits_b", arvalid, 0);
    check("wvalid_off", wvalid, 0);
    step();
    #1 check("ar_still_waits_b", arvalid, 0);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    #1 check("ar_after_b", arvalid, 1);
    check("araddr_wb", araddr, raddr);
    check("bready_off", bready, 0);
    step();
`endif
    r_phase(base, -1, gap);
    #1 check("wb_reload_pulse", reload, 1);
    step();
    #1 check("wb_reload_once", reload_cnt - rl0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rl0;
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; rd_addr = '0; wr_addr = '0;
    arready = 1'b1; awready = 1'b1; wready = 1'b0;
    rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    bresp = 2'b00; bvalid = 1'b0;
    step();
    step();
    #1 check("rst_reload", reload, 0);
    check("rst_valids", {arvalid, awvalid, wvalid, bready, rready}, 5'b0);
    check("rst_ref_we", ref_we, 0);
    check("rst_idx", {vic_idx, ref_idx}, 6'd0);
    check("rst_bus_err", bus_err, 0);
    rst = 1'b0;
    step();

    clean_miss(32'h0000_1240, 32'hA0, -1, 0);
    check("no_err_clean", bus_err, 0);

    dirty_miss(32'h0008_3240, 32'h0000_4000, 32'hB0, 1'b0, 0);
    dirty_miss(32'h0008_4000, 32'h0000_5000, 32'hC0, 1'b1, 2);
    check("no_err_dirty", bus_err, 0);

    clean_miss(32'h0000_6000, 32'hD0, 3, 0);
    check("bus_err_set", bus_err, 1);
    clean_miss(32'h0000_6040, 32'hE0, -1, 1);
    check("bus_err_sticky", bus_err, 1);

    // Reset after R beat 4 of a refill.
    rl0 = reload_cnt;
    rd_req = 1'b1; rd_addr = 32'h0000_7040;
    step();
    rd_req = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      rvalid = 1'b1;
      rdata  = 32'h90 + k;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1 check("mid_rst_rready", rready, 0);
    check("mid_rst_ref_we", ref_we, 0);
    check("mid_rst_valids", {arvalid, awvalid, wvalid, bready}, 4'b0);
    check("mid_rst_bus_err", bus_err, 0);
    rvalid = 1'b0;
    for (int c = 0; c < 4; c++) step();
    check("mid_rst_no_reload", reload_cnt - rl0, 0);

    clean_miss(32'h0000_7000, 32'hF0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_axi_refill.md
# dcache_axi_refill

Line-refill and write-back engine between the data cache's miss outputs and the AXI4 master port. It takes the cache's `rd_req`/`rd_addr` and `wr_req`/`wr_addr` miss signals. When the victim line is marked for write-back, it first bursts that line out (8×32-bit beats, one 32-byte line). It then bursts the missing line in, streams each beat into the cache data RAM, and pulses `reload` for one cycle so the cache installs the new tag and releases its stall.

## Interface
Parameters:
- `AXI_ID`, 4'd1: value driven on `arid`/`awid`.
- `LINE_BEATS`, 8: beats per line; fixed at 8 (3-bit beat counter, 32-byte lines).

Ports (`rst` is synchronous, active-high):
- `clk` in 1: single clock.
- `rst` in 1: synchronous active-high reset.
- `rd_req` in 1: miss pending; `rd_addr` in 32: line-aligned refill address.
- `wr_req` in 1: victim is valid and must be written back; `wr_addr` in 32: victim line address.
- `reload` out 1: one-cycle pulse that commits the tag in the cache.
- `vic_idx` out 3: word index for the victim data RAM read; `vic_rdata` in 32: victim word, combinational same-cycle read.
- `ref_we` out 1, `ref_idx` out 3, `ref_wdata` out 32: refill write port to the cache data RAM.
- `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arvalid` out 1, `arready` in 1.
- `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1.
- `awid` out 4, `awaddr` out 32, `awlen` out 8, `awsize` out 3, `awburst` out 2, `awvalid` out 1, `awready` in 1.
- `wdata` out 32, `wstrb` out 4, `wlast` out 1, `wvalid` out 1, `wready` in 1.
- `bresp` in 2, `bvalid` in 1, `bready` out 1.
- `bus_err` out 1: sticky flag, set by any non-OKAY `rresp` or `bresp`; cleared only by `rst`.

## Operation
- Constant outputs: `arlen`/`awlen` = 7, `arsize`/`awsize` = 3'b010, `arburst`/`awburst` = INCR (2'b01), `wstrb` = 4'hF.
- States: IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R, DONE.
- IDLE:
  - On `rd_req`, latch `rd_addr` into `araddr` and `wr_addr` into `awaddr`, and clear the beat counter.
  - Go to WB_AW if `wr_req`, else to RD_AR.
- WB_AW: `awvalid`=1. On `awready`, go to WB_W.
- WB_W:
  - `wvalid`=1, `vic_idx` = beat, `wdata` = `vic_rdata`, `wlast` = (beat==7).
  - The beat counter increments on each `wvalid&wready`.
  - After the beat-7 handshake, go to WB_B; the counter wraps to 0.
- WB_B: `bready`=1. On `bvalid`, go to RD_AR.
- RD_AR: `arvalid`=1. On `arready`, go to RD_R.
- RD_R:
  - `rready`=1, `ref_we` = `rvalid`, `ref_idx` = beat, `ref_wdata` = `rdata`.
  - The counter increments per `rvalid` beat.
  - After the beat-7 handshake, go to DONE. `rlast` is not used for sequencing.
- DONE: `reload`=1 for exactly one cycle, then go to IDLE.
- Address stability: latched addresses hold until the next IDLE acceptance, regardless of `rd_addr` changes.
- Re-trigger: a `rd_req` still asserted in the first IDLE cycle after DONE is not re-serviced if the cache now hits. `rd_req` is expected to drop the cycle after `reload`, since the tag RAM read is asynchronous.

## Timing
- Reset: state=IDLE, beat=0, `bus_err`=0. All outputs are 0: `reload`, `arvalid`, `awvalid`, `wvalid`, `bready`, `rready`, `ref_we`, `vic_idx`, `ref_idx`.
- Valid/ready rules:
  - Each `*valid` is held high until its handshake.
  - No combinational path from any `*ready` to the same channel's `*valid`.
  - `rready` is a registered state decode only.
- `rst` mid-burst: everything returns to IDLE next cycle and all valids drop. The interconnect is reset together with this block.
- Minimum miss latency, no write-back, zero-wait slave: IDLE→RD_AR→RD_R×8→DONE gives `reload` 11 cycles after `rd_req` is sampled.
- Write-back adds AW + 8 W beats + B, i.e. ≥10 cycles.
- Back-pressure: `wvalid` with `wready`=0 holds `wdata`/`vic_idx` stable. `rvalid`=0 gaps stall the counter.

## Configuration
- `DCACHE_WB_OVERLAP_EN`
- Defined:
  - After the last W handshake, go directly to RD_AR and raise a `b_pending` flag.
  - `bready` stays high while `b_pending`; `bvalid` clears it.
  - After the last R beat, DONE is entered only when `b_pending`=0; otherwise the block waits in WB_B.
  - This saves the B round-trip before the refill.
- Undefined: strict WB_B wait before AR as described above. `b_pending` is not implemented.

## Test plan
- Clean miss: `rd_req`=1, `wr_req`=0, `rd_addr`=0x0000_1240, zero-wait slave returning 0xA0..0xA7 → `araddr`=0x1240, `arlen`=7, `ref_we` 8 cycles with `ref_idx` 0..7 and data 0xA0..0xA7, `reload` high exactly once at cycle 11, no AW activity.
- Dirty miss: `wr_req`=1, `wr_addr`=0x0008_3240, `vic_rdata`=0x5500+idx → `awaddr`=0x83240, `wdata` 0x5500..0x5507, `wlast` only on the 8th beat. AR is issued only after `bvalid` (macro off), or right after WLAST (macro on).
- Back-pressure: `wready` toggling 1/0 and `rvalid` gaps of 2 cycles → no lost or duplicated beats, `wdata` stable while stalled, `reload` after the 8th R beat.
- Error response: `rresp`=2'b10 on beat 3 → `bus_err`=1 and stays 1. The refill still completes with `reload`.
- Reset mid-refill: `rst` asserted after R beat 4 → next cycle state IDLE, `rready`=0, `ref_we`=0, `reload` never pulses. A fresh `rd_req` then starts from beat 0.
